ps2_keycode_receiver: RTL and testbench

- Upstream neighbour of the keycode decoder.
- Receives 11-bit PS/2 device-to-host frames from the keyboard pins: start, 8 data bits LSB first, odd parity, stop.
- Each good byte is shifted into a 32-bit scancode history. The decoder reads the newest byte from keycode[7:0]; make/break/extended context sits in the upper bytes.
- Single clock domain; the PS/2 pins are asynchronous inputs.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_keycode_receiver.sv | 150 +++++++++++++++
 tb/tb_ps2_keycode_receiver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding and protocol byte constants.
// No logic; imported by the receiver and its bench.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXTENDED   = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose: 2-FF synchronise a raw PS/2 line, reject pulses shorter than FILTER_LEN, strobe filtered falls.
// Latency: 2 sync cycles + FILTER_LEN run samples + 1 register to level_out/fall_edge.
// Backpressure: none; free-running sampler, fall_edge is a one-cycle strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic fall_edge
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            level_out <= 1'b1;
            run_cnt   <= '0;
            fall_edge <= 1'b0;
        end else begin
            sync_q1   <= raw_in;
            sync_q2   <= sync_q1;
            fall_edge <= 1'b0;
            // Any sample that agrees with the filtered level restarts the run.
            if (sync_q2 != level_out) begin
                if (run_cnt == CW'(FILTER_LEN - 1)) begin
                    level_out <= sync_q2;
                    run_cnt   <= '0;
                    fall_edge <= ~sync_q2;
                end else begin
                    run_cnt <= run_cnt + CW'(1);
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_receiver.sv
// Purpose: receive PS/2 device-to-host frames and shift each good byte into a 32-bit scancode history.
// Latency: keycode/keycode_valid/parity_err/frame_err update 1 cycle after the stop-bit fall strobe.
// Backpressure: none; the keyboard cannot be stalled, pulses are single-cycle and must be consumed.
module ps2_keycode_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keycode,
    output logic        keycode_valid,
    output logic        parity_err,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_lvl;
    logic          clk_fall;
    logic          bit_strobe;
    logic          data_q1;
    logic          data_s;

    ps2_state_t    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [31:0]   keycode_d;
    logic          valid_d;
    logic          perr_d;
    logic          ferr_d;
    logic          timeout;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filt (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (ps2_clk),
        .level_out (clk_lvl),
        .fall_edge (clk_fall)
    );

    // Data is only synchronised: it is sampled a full filter delay after the
    // pin edge, deep inside the bit's stable window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q1 <= 1'b1;
            data_s  <= 1'b1;
        end else begin
            data_q1 <= ps2_data;
            data_s  <= data_q1;
        end
    end

    assign bit_strobe = clk_fall & ~clk_lvl;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        tcnt_d    = '0;
        keycode_d = keycode;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        timeout   = 1'b0;

        if (state_q != IDLE) begin
            tcnt_d  = bit_strobe ? '0 : tcnt_q + TW'(1);
            timeout = !bit_strobe && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
        end

        case (state_q)
            IDLE: begin
                if (bit_strobe && !data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    shreg_d   = {data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_strobe) begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    // Bad parity is reported even when the stop bit is also wrong.
                    if (!(^{shreg_q, parity_q})) begin
                        perr_d = 1'b1;
                    end else if (!data_s) begin
                        ferr_d = 1'b1;
                    end else begin
                        keycode_d = {keycode[23:0], shreg_q};
                        valid_d   = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d = IDLE;
            tcnt_d  = '0;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= 8'h00;
            parity_q      <= 1'b0;
            tcnt_q        <= '0;
            keycode       <= 32'h0;
            keycode_valid <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            parity_q      <= parity_d;
            tcnt_q        <= tcnt_d;
            keycode       <= keycode_d;
            keycode_valid <= valid_d;
            parity_err    <= perr_d;
            frame_err     <= ferr_d;
        end
    end

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Directed bench for ps2_keycode_receiver: good frames, parity/stop errors, glitches,
// timeout and mid-frame reset, with pulse counters and latency/exclusivity monitors.
module tb_ps2_keycode_receiver;
    import ps2_pkg::*;

    localparam int FL = 8;
    localparam int TO = 20000;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] keycode;
    logic        keycode_valid;
    logic        parity_err;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_fall = 0, n_multi = 0, n_late = 0;
    int v0, p0, f0, e0;
    logic prev_fall = 1'b0;

    always #5 clk = ~clk;

    ps2_keycode_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .keycode       (keycode),
        .keycode_valid (keycode_valid),
        .parity_err    (parity_err),
        .frame_err     (frame_err)
    );

    // Pulse counters; valid/parity pulses must follow a fall strobe by exactly one cycle.
    always @(negedge clk) begin
        if (keycode_valid) n_valid++;
        if (parity_err)    n_perr++;
        if (frame_err)     n_ferr++;
        if (int'(keycode_valid) + int'(parity_err) + int'(frame_err) > 1) n_multi++;
        if ((keycode_valid || parity_err) && !prev_fall) n_late++;
        if (dut.clk_fall) n_fall++;
        prev_fall = dut.clk_fall;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        v0 = n_valid; p0 = n_perr; f0 = n_ferr; e0 = n_fall;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(20);
        ps2_clk = 1'b0;
        wait_cyc(40);
        ps2_clk = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        logic [PS2_FRAME_BITS-1:0] fr;
        fr = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < PS2_FRAME_BITS; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    task automatic check_deltas(input string tag, input int dv, input int dp, input int df);
        check({tag, "_valid"}, 32'(n_valid - v0), 32'(dv));
        check({tag, "_perr"},  32'(n_perr - p0),  32'(dp));
        check({tag, "_ferr"},  32'(n_ferr - f0),  32'(df));
    endtask

    initial begin
        wait_cyc(5);
        check("rst_keycode", keycode, 32'h0);
        check("rst_valid", 32'(keycode_valid), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        wait_cyc(5);

        // Single good frame
        snap();
        send_frame(8'h75, 1'b0, 1'b1);
        check("f75_keycode", keycode, 32'h0000_0075);
        check_deltas("f75", 1, 0, 0);

        // Extended break sequence from a clean history
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        snap();
        send_frame(PS2_EXTENDED, 1'b0, 1'b1);
        send_frame(PS2_BREAK, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        check("b2b_keycode", keycode, 32'h00E0_F074);
        check_deltas("b2b", 3, 0, 0);

        // Bad parity, then a good frame
        snap();
        send_frame(8'h6B, 1'b1, 1'b1);
        check("perr_keycode", keycode, 32'h00E0_F074);
        check_deltas("perr", 0, 1, 0);
        send_frame(8'h72, 1'b0, 1'b1);
        check("after_perr_low", 32'(keycode[7:0]), 32'h72);
        check("after_perr_keycode", keycode, 32'hE0F0_7472);

        // Bad stop bit
        snap();
        send_frame(8'h72, 1'b0, 1'b0);
        check("stop_keycode", keycode, 32'hE0F0_7472);
        check_deltas("stop", 0, 0, 1);

        // Short glitch is filtered out
        snap();
        ps2_clk = 1'b0;
        wait_cyc(FL - 2);
        ps2_clk = 1'b1;
        wait_cyc(30);
        check("glitch_short_fall", 32'(n_fall - e0), 32'h0);
        check_deltas("glitch_short", 0, 0, 0);

        // Glitch of exactly FILTER_LEN with data high: false start
        snap();
        ps2_data = 1'b1;
        ps2_clk = 1'b0;
        wait_cyc(FL);
        ps2_clk = 1'b1;
        wait_cyc(30);
        check("glitch_full_fall", 32'(n_fall - e0), 32'h1);
        check("glitch_full_state", 32'(dut.state_q), 32'(IDLE));
        check_deltas("glitch_full", 0, 0, 0);

        // Frame stalls after 5 data bits -> timeout
        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'(8'h75 >> i));
        ps2_data = 1'b1;
        wait_cyc(TO + 10);
        check("tmo_keycode", keycode, 32'hE0F0_7472);
        check("tmo_state", 32'(dut.state_q), 32'(IDLE));
        check_deltas("tmo", 0, 0, 1);
        snap();
        send_frame(8'h75, 1'b0, 1'b1);
        check("after_tmo_keycode", keycode, 32'hF074_7275);
        check_deltas("after_tmo", 1, 0, 0);

        // Reset in the middle of a frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        rst_n = 1'b0;
        wait_cyc(3);
        check("midrst_keycode", keycode, 32'h0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        wait_cyc(5);
        snap();
        send_frame(8'h6B, 1'b0, 1'b1);
        check("midrst_6b_keycode", keycode, 32'h0000_006B);
        check_deltas("midrst_6b", 1, 0, 0);

        check("pulse_exclusive", 32'(n_multi), 32'h0);
        check("pulse_latency", 32'(n_late), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
